// File: rtl/button_event.sv
// rtl/button_event.sv - debounced button level to press/held/release UI events; AUTO_REPEAT_EN enables auto-repeat press pulses
// The release pulse port is named "released" because "release" is a reserved word.
module button_event #(
    parameter int HOLD_DELAY    = 32500000,
    parameter int REPEAT_PERIOD = 6500000,
    parameter int NBITS         = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic clean,
    output logic press,
    output logic held,
    output logic released
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [NBITS-1:0] HOLD_LAST   = NBITS'(HOLD_DELAY - 1);
    localparam logic [NBITS-1:0] REPEAT_LAST = NBITS'(REPEAT_PERIOD - 1);

    state_t           state;
    state_t           state_next;
    logic [NBITS-1:0] count;
    logic [NBITS-1:0] count_next;
    logic             prev;
    logic             press_next;
    logic             held_next;
    logic             released_next;

    // State, counter, edge-detect history and registered outputs.
    // prev loads clean even during reset so a button held through reset
    // never looks like a fresh rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            press    <= 1'b0;
            held     <= 1'b0;
            released <= 1'b0;
            prev     <= clean;
        end else begin
            state    <= state_next;
            count    <= count_next;
            press    <= press_next;
            held     <= held_next;
            released <= released_next;
            prev     <= clean;
        end
    end

    // Next-state and next-output decode; release always has priority over
    // a terminal count on the same edge.
    always_comb begin
        state_next    = state;
        count_next    = count;
        press_next    = 1'b0;
        held_next     = held;
        released_next = 1'b0;
        unique case (state)
            IDLE: begin
                held_next = 1'b0;
                if (clean && !prev) begin
                    press_next = 1'b1;
                    count_next = '0;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!clean) begin
                    released_next = 1'b1;
                    count_next    = '0;
                    state_next    = IDLE;
                end else if (count == HOLD_LAST) begin
`ifdef AUTO_REPEAT_EN
                    press_next = 1'b1;
`endif
                    held_next  = 1'b1;
                    count_next = '0;
                    state_next = REPEAT;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            REPEAT: begin
                if (!clean) begin
                    released_next = 1'b1;
                    held_next     = 1'b0;
                    count_next    = '0;
                    state_next    = IDLE;
                end else if (count == REPEAT_LAST) begin
`ifdef AUTO_REPEAT_EN
                    press_next = 1'b1;
`endif
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                held_next  = 1'b0;
                count_next = '0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - table-driven directed bench for button_event (expectations follow AUTO_REPEAT_EN)
module tb_button_event;

    logic clk = 1'b0;
    logic reset;
    logic clean;
    logic press;
    logic held;
    logic released;

    int nvec  = 0;
    int nfail = 0;

`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    button_event #(
        .HOLD_DELAY   (8),
        .REPEAT_PERIOD(4),
        .NBITS        (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clean   (clean),
        .press   (press),
        .held    (held),
        .released(released)
    );

    always #5 clk = ~clk;

    // exp is {press, held, release} expected after the edge that samples rst/cln
    typedef struct {
        bit       rst;
        bit       cln;
        bit [2:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input bit r, input bit c, input bit [2:0] e);
        vec_t v;
        v.rst = r;
        v.cln = c;
        v.exp = e;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic apply(input bit r, input bit c, input bit [2:0] e, input string name, input int idx);
        reset = r;
        clean = c;
        @(posedge clk);
        #1;
        nvec++;
        if ({press, held, released} !== e) begin
            nfail++;
            $display("FAIL %s[%0d]: {press,held,release} got %b%b%b expected %b",
                     name, idx, press, held, released, e);
        end
    endtask

    initial begin
        reset = 1'b1;
        clean = 1'b0;

        // Scenario 1: short press, plus immediate re-press after release
        add(2, 1, 0, 3'b000);
        add(1, 0, 0, 3'b000);
        add(1, 0, 1, 3'b100);
        add(2, 0, 1, 3'b000);
        add(1, 0, 0, 3'b001);
        add(1, 0, 1, 3'b100);
        add(1, 0, 0, 3'b001);
        add(2, 0, 0, 3'b000);

        // Scenario 2 / 6: long hold of 20 cycles
        add(1, 0, 1, 3'b100);
        add(7, 0, 1, 3'b000);
        add(1, 0, 1, {AR, 2'b10});
        for (int c = 9; c <= 19; c++)
            add(1, 0, 1, {AR && (c == 12 || c == 16), 2'b10});
        add(1, 0, 0, 3'b001);
        add(2, 0, 0, 3'b000);

        // Scenario 5: release sampled on the edge where HOLD count is terminal
        add(1, 0, 1, 3'b100);
        add(7, 0, 1, 3'b000);
        add(1, 0, 0, 3'b001);
        add(2, 0, 0, 3'b000);

        foreach (tbl[i]) apply(tbl[i].rst, tbl[i].cln, tbl[i].exp, "table", i);

        // Scenario 3: button held down through reset produces nothing
        apply(1, 1, 3'b000, "held_reset", 0);
        for (int i = 0; i < 30; i++) apply(0, 1, 3'b000, "held_reset_quiet", i);
        apply(0, 0, 3'b000, "held_reset_fall", 0);
        apply(0, 0, 3'b000, "held_reset_fall", 1);
        apply(0, 1, 3'b100, "held_reset_repress", 0);
        apply(0, 0, 3'b001, "held_reset_release", 0);
        apply(0, 0, 3'b000, "held_reset_idle", 0);

        // Scenario 4: reset at cycle 10 of a long hold aborts without release
        apply(0, 1, 3'b100, "mid_reset_press", 0);
        for (int c = 1; c <= 9; c++)
            apply(0, 1, (c == 8) ? {AR, 2'b10} : (c > 8 ? 3'b010 : 3'b000), "mid_reset_hold", c);
        apply(1, 1, 3'b000, "mid_reset_abort", 10);
        for (int i = 0; i < 5; i++) apply(0, 1, 3'b000, "mid_reset_quiet", i);
        apply(0, 0, 3'b000, "mid_reset_no_release", 0);
        apply(0, 1, 3'b100, "mid_reset_repress", 0);
        apply(0, 0, 3'b001, "mid_reset_release", 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
